// File: rtl/brick_game_ctrl.sv
// Breakout game sequencer: serve/play/lose/win flow and once-per-frame
// ball-versus-brick-grid hit detection with brick clear commands.
module brick_game_ctrl #(
    parameter int SCREEN_H     = 480,
    parameter int GRID_X0      = 64,
    parameter int GRID_Y0      = 64,
    parameter int CELL_W_LG2   = 6,
    parameter int CELL_H_LG2   = 5,
    parameter int COLS         = 8,
    parameter int ROWS         = 3,
    parameter int LIVES        = 3,
    parameter int SERVE_FRAMES = 60
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        frame_tick,
    input  logic        btn_start,
    input  logic [10:0] ball_v,
    input  logic [10:0] ball_h,
    input  logic        ball_lost,
    input  logic [23:0] bricks,
    output logic        brick_clr,
    output logic [4:0]  brick_idx,
    output logic        bricks_rst,
    output logic        bounce_v,
    output logic        ball_run,
    output logic [7:0]  score,
    output logic [1:0]  lives,
    output logic [2:0]  state
);

    localparam int CW = $clog2(SERVE_FRAMES);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_SERVE = 3'd1,
        S_PLAY  = 3'd2,
        S_CHECK = 3'd3,
        S_CLEAR = 3'd4,
        S_LOST  = 3'd5,
        S_WIN   = 3'd6,
        S_OVER  = 3'd7
    } state_t;

    state_t        state_q, state_d;
    logic [7:0]    score_q, score_d;
    logic [1:0]    lives_q, lives_d;
    logic [4:0]    left_q, left_d;
    logic [CW-1:0] serve_cnt_q, serve_cnt_d;
    logic [10:0]   v_q, v_d, h_q, h_d;
    logic          brick_clr_q, brick_clr_d;
    logic [4:0]    brick_idx_q, brick_idx_d;
    logic          bricks_rst_q, bricks_rst_d;
    logic          bounce_q, bounce_d;
    logic          ball_run_q, ball_run_d;

    logic [11:0] y, dx, dy;
    logic        in_x, in_y, hit;
    logic [4:0]  idx;

    // Grid y grows upward from the screen bottom; ball_v below the screen misses.
    always_comb begin
        y    = 12'(SCREEN_H) - {1'b0, v_q};
        dx   = {1'b0, h_q} - 12'(GRID_X0);
        dy   = y - 12'(GRID_Y0);
        in_x = ({1'b0, h_q} >= 12'(GRID_X0)) &&
               ({1'b0, h_q} < 12'(GRID_X0 + (COLS << CELL_W_LG2)));
        in_y = ({1'b0, v_q} <= 12'(SCREEN_H)) &&
               (y >= 12'(GRID_Y0)) &&
               (y < 12'(GRID_Y0 + (ROWS << CELL_H_LG2)));
        idx  = 5'(5'(dy >> CELL_H_LG2) * 5'(COLS) + 5'(dx >> CELL_W_LG2));
        hit  = in_x && in_y && bricks[idx];
    end

    always_comb begin
        state_d      = state_q;
        score_d      = score_q;
        lives_d      = lives_q;
        left_d       = left_q;
        serve_cnt_d  = serve_cnt_q;
        v_d          = v_q;
        h_d          = h_q;
        brick_clr_d  = 1'b0;
        brick_idx_d  = brick_idx_q;
        bricks_rst_d = 1'b0;
        bounce_d     = 1'b0;

        unique case (state_q)
            S_IDLE, S_OVER, S_WIN: begin
                if (btn_start) begin
                    bricks_rst_d = 1'b1;
                    left_d       = 5'(ROWS * COLS);
                    serve_cnt_d  = '0;
                    state_d      = S_SERVE;
                    if (state_q != S_WIN) begin
                        score_d = '0;
                        lives_d = 2'(LIVES);
                    end
                end
            end
            S_SERVE: begin
                if (frame_tick) begin
                    if (serve_cnt_q == CW'(SERVE_FRAMES - 1)) begin
                        serve_cnt_d = '0;
                        state_d     = S_PLAY;
                    end else begin
                        serve_cnt_d = serve_cnt_q + 1'b1;
                    end
                end
            end
            S_PLAY: begin
                if (frame_tick) begin
                    if (ball_lost) begin
                        state_d = S_LOST;
                    end else begin
                        v_d     = ball_v;
                        h_d     = ball_h;
                        state_d = S_CHECK;
                    end
                end
            end
            S_CHECK: begin
                if (hit) begin
                    brick_clr_d = 1'b1;
                    bounce_d    = 1'b1;
                    brick_idx_d = idx;
                    score_d     = (score_q == 8'hFF) ? score_q : score_q + 8'd1;
                    left_d      = left_q - 5'd1;
                    state_d     = S_CLEAR;
                end else begin
                    state_d = S_PLAY;
                end
            end
            S_CLEAR: begin
                state_d = (left_q == 5'd0) ? S_WIN : S_PLAY;
            end
            S_LOST: begin
                lives_d     = lives_q - 2'd1;
                serve_cnt_d = '0;
                state_d     = (lives_q == 2'd1) ? S_OVER : S_SERVE;
            end
        endcase

        ball_run_d = (state_d == S_PLAY) || (state_d == S_CHECK) ||
                     (state_d == S_CLEAR);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_IDLE;
            score_q      <= '0;
            lives_q      <= 2'(LIVES);
            left_q       <= 5'(ROWS * COLS);
            serve_cnt_q  <= '0;
            v_q          <= '0;
            h_q          <= '0;
            brick_clr_q  <= 1'b0;
            brick_idx_q  <= '0;
            bricks_rst_q <= 1'b0;
            bounce_q     <= 1'b0;
            ball_run_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            score_q      <= score_d;
            lives_q      <= lives_d;
            left_q       <= left_d;
            serve_cnt_q  <= serve_cnt_d;
            v_q          <= v_d;
            h_q          <= h_d;
            brick_clr_q  <= brick_clr_d;
            brick_idx_q  <= brick_idx_d;
            bricks_rst_q <= bricks_rst_d;
            bounce_q     <= bounce_d;
            ball_run_q   <= ball_run_d;
        end
    end

    assign brick_clr  = brick_clr_q;
    assign brick_idx  = brick_idx_q;
    assign bricks_rst = bricks_rst_q;
    assign bounce_v   = bounce_q;
    assign ball_run   = ball_run_q;
    assign score      = score_q;
    assign lives      = lives_q;
    assign state      = state_q;

endmodule

// File: tb/tb_brick_game_ctrl.sv
// Self-checking bench for brick_game_ctrl with a behavioural grid/game model.
module tb_brick_game_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        frame_tick;
    logic        btn_start;
    logic [10:0] ball_v;
    logic [10:0] ball_h;
    logic        ball_lost;
    logic [23:0] bricks;
    logic        brick_clr;
    logic [4:0]  brick_idx;
    logic        bricks_rst;
    logic        bounce_v;
    logic        ball_run;
    logic [7:0]  score;
    logic [1:0]  lives;
    logic [2:0]  state;

    int total = 0;
    int bad   = 0;
    int exp_score = 0;
    int exp_left  = 24;

    brick_game_ctrl dut (
        .clk        (clk),
        .rst        (rst),
        .frame_tick (frame_tick),
        .btn_start  (btn_start),
        .ball_v     (ball_v),
        .ball_h     (ball_h),
        .ball_lost  (ball_lost),
        .bricks     (bricks),
        .brick_clr  (brick_clr),
        .brick_idx  (brick_idx),
        .bricks_rst (bricks_rst),
        .bounce_v   (bounce_v),
        .ball_run   (ball_run),
        .score      (score),
        .lives      (lives),
        .state      (state)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic tick();
        frame_tick = 1'b1;
        step();
        frame_tick = 1'b0;
        step();
    endtask

    // Screen-space reference: which brick (if any) a ball position lands on.
    function automatic void model_hit(input int v, input int h,
                                      output bit hit, output int idx);
        int y;
        hit = 0;
        idx = -1;
        y = 480 - v;
        if (v <= 480 && h >= 64 && h < 64 + 8 * 64 && y >= 64 && y < 64 + 3 * 32) begin
            idx = ((y - 64) / 32) * 8 + (h - 64) / 64;
            hit = bricks[idx];
        end
    endfunction

    // Plays one frame from PLAY; the bench acts as the brick store.
    task automatic do_frame(input int v, input int h, input bit lost,
                            output bit clr, output int idx, output bit bnc);
        ball_v     = 11'(v);
        ball_h     = 11'(h);
        ball_lost  = lost;
        frame_tick = 1'b1;
        step();
        frame_tick = 1'b0;
        ball_lost  = 1'b0;
        clr = 0;
        bnc = 0;
        idx = -1;
        for (int i = 0; i < 4; i++) begin
            step();
            if (brick_clr) begin
                clr = 1;
                idx = int'(brick_idx);
                bnc = bounce_v;
                bricks[brick_idx] = 1'b0;
            end
            if (!(state inside {3'd3, 3'd4, 3'd5})) break;
        end
    endtask

    task automatic serve_wait();
        int n = 0;
        while (state != 3'd2 && n < 70) begin
            tick();
            n++;
        end
        total++;
        if (state !== 3'd2) begin
            bad++;
            $display("FAIL serve_wait state=%0d required=2", state);
        end
    endtask

    task automatic press_start();
        btn_start = 1'b1;
        step();
        btn_start = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step();
        step();
        total++;
        if (state !== 3'd0 || score !== 8'd0 || lives !== 2'd3 || ball_run !== 1'b0 ||
            brick_clr !== 1'b0 || brick_idx !== 5'd0 || bricks_rst !== 1'b0 ||
            bounce_v !== 1'b0) begin
            bad++;
            $display("FAIL reset state=%0d score=%0d lives=%0d run=%b clr=%b idx=%0d rst=%b bnc=%b",
                     state, score, lives, ball_run, brick_clr, brick_idx, bricks_rst, bounce_v);
        end
        rst = 1'b0;
        step();
    endtask

    task automatic test_start();
        press_start();
        total++;
        if (bricks_rst !== 1'b1 || state !== 3'd1 || lives !== 2'd3 ||
            score !== 8'd0 || ball_run !== 1'b0) begin
            bad++;
            $display("FAIL start rst=%b state=%0d lives=%0d score=%0d run=%b required 1/1/3/0/0",
                     bricks_rst, state, lives, score, ball_run);
        end
        bricks = '1;
        step();
        total++;
        if (bricks_rst !== 1'b0) begin
            bad++;
            $display("FAIL start_pulse bricks_rst=%b required=0", bricks_rst);
        end
    endtask

    task automatic test_serve();
        for (int i = 0; i < 59; i++) tick();
        total++;
        if (state !== 3'd1 || ball_run !== 1'b0) begin
            bad++;
            $display("FAIL serve_59 state=%0d run=%b required 1/0", state, ball_run);
        end
        frame_tick = 1'b1;
        step();
        frame_tick = 1'b0;
        total++;
        if (state !== 3'd2 || ball_run !== 1'b1) begin
            bad++;
            $display("FAIL serve_60 state=%0d run=%b required 2/1", state, ball_run);
        end
    endtask

    task automatic test_hit();
        bit clr, bnc;
        int idx;
        do_frame(400, 130, 0, clr, idx, bnc);
        exp_score++;
        exp_left--;
        total++;
        if (!clr || idx != 1 || !bnc || score !== 8'(exp_score) || state !== 3'd2) begin
            bad++;
            $display("FAIL hit1 clr=%b idx=%0d bnc=%b score=%0d state=%0d required 1/1/1/%0d/2",
                     clr, idx, bnc, score, state, exp_score);
        end
        do_frame(400, 130, 0, clr, idx, bnc);
        total++;
        if (clr || score !== 8'(exp_score) || state !== 3'd2 || ball_run !== 1'b1) begin
            bad++;
            $display("FAIL hit_gone clr=%b score=%0d state=%0d run=%b required 0/%0d/2/1",
                     clr, score, state, ball_run, exp_score);
        end
        press_start();
        total++;
        if (state !== 3'd2 || bricks_rst !== 1'b0) begin
            bad++;
            $display("FAIL btn_in_play state=%0d bricks_rst=%b required 2/0", state, bricks_rst);
        end
    endtask

    task automatic test_boundaries();
        bit clr, bnc;
        int idx;
        int vs[5] = '{400, 320, 500, 321, 416};
        int hs[5] = '{576, 130, 130, 575, 64};
        int ei[5] = '{-1, -1, -1, 23, 0};
        for (int k = 0; k < 5; k++) begin
            do_frame(vs[k], hs[k], 0, clr, idx, bnc);
            if (ei[k] >= 0) begin
                exp_score++;
                exp_left--;
            end
            total++;
            if (clr != (ei[k] >= 0) || (clr && idx != ei[k]) || state !== 3'd2 ||
                score !== 8'(exp_score)) begin
                bad++;
                $display("FAIL boundary%0d clr=%b idx=%0d score=%0d state=%0d required idx=%0d score=%0d",
                         k, clr, idx, score, state, ei[k], exp_score);
            end
        end
    endtask

    task automatic test_random();
        bit clr, bnc, hit;
        int idx, midx, v, h;
        for (int k = 0; k < 20; k++) begin
            v = int'($urandom_range(300, 500));
            h = int'($urandom_range(40, 600));
            model_hit(v, h, hit, midx);
            do_frame(v, h, 0, clr, idx, bnc);
            if (hit) begin
                exp_score++;
                exp_left--;
            end
            total++;
            if (clr != hit || (hit && (idx != midx || !bnc)) ||
                score !== 8'(exp_score) || state !== 3'd2) begin
                bad++;
                $display("FAIL random v=%0d h=%0d clr=%b idx=%0d score=%0d state=%0d required %b/%0d/%0d/2",
                         v, h, clr, idx, score, state, hit, midx, exp_score);
            end
        end
    endtask

    task automatic test_lose();
        bit clr, bnc;
        int idx;
        for (int k = 0; k < 3; k++) begin
            do_frame(400, 200 + 64 * k, 1, clr, idx, bnc);
            total++;
            if (clr || lives !== 2'(2 - k) || state !== ((k == 2) ? 3'd7 : 3'd1) ||
                ball_run !== 1'b0 || score !== 8'(exp_score)) begin
                bad++;
                $display("FAIL lose%0d clr=%b lives=%0d state=%0d run=%b required 0/%0d/%0d/0",
                         k, clr, lives, state, ball_run, 2 - k, (k == 2) ? 7 : 1);
            end
            if (k < 2) serve_wait();
        end
        press_start();
        exp_score = 0;
        exp_left  = 24;
        total++;
        if (bricks_rst !== 1'b1 || lives !== 2'd3 || score !== 8'd0 || state !== 3'd1) begin
            bad++;
            $display("FAIL new_game rst=%b lives=%0d score=%0d state=%0d required 1/3/0/1",
                     bricks_rst, lives, score, state);
        end
        bricks = '1;
    endtask

    task automatic test_win();
        bit clr, bnc;
        int idx, h, y;
        int misses = 0;
        serve_wait();
        for (int b = 0; b < 24; b++) begin
            h = 64 + (b % 8) * 64 + int'($urandom_range(0, 63));
            y = 64 + (b / 8) * 32 + int'($urandom_range(0, 31));
            do_frame(480 - y, h, 0, clr, idx, bnc);
            if (!clr || idx != b) misses++;
        end
        total++;
        if (misses != 0) begin
            bad++;
            $display("FAIL win_clears misses=%0d required=0", misses);
        end
        total++;
        if (state !== 3'd6 || score !== 8'd24 || ball_run !== 1'b0) begin
            bad++;
            $display("FAIL win state=%0d score=%0d run=%b required 6/24/0", state, score, ball_run);
        end
        press_start();
        total++;
        if (bricks_rst !== 1'b1 || state !== 3'd1 || score !== 8'd24 || lives !== 2'd3) begin
            bad++;
            $display("FAIL win_restart rst=%b state=%0d score=%0d lives=%0d required 1/1/24/3",
                     bricks_rst, state, score, lives);
        end
        bricks = '1;
    endtask

    task automatic test_reset_mid();
        serve_wait();
        @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        total++;
        if (state !== 3'd0 || score !== 8'd0 || lives !== 2'd3 || ball_run !== 1'b0 ||
            brick_clr !== 1'b0 || brick_idx !== 5'd0 || bricks_rst !== 1'b0 ||
            bounce_v !== 1'b0) begin
            bad++;
            $display("FAIL reset_mid state=%0d score=%0d lives=%0d run=%b idx=%0d",
                     state, score, lives, ball_run, brick_idx);
        end
        step();
        rst = 1'b0;
        step();
    endtask

    initial begin
        rst        = 1'b1;
        frame_tick = 1'b0;
        btn_start  = 1'b0;
        ball_v     = '0;
        ball_h     = '0;
        ball_lost  = 1'b0;
        bricks     = '1;
        test_reset();
        test_start();
        test_serve();
        test_hit();
        test_boundaries();
        test_random();
        test_lose();
        test_win();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
